mem_sram_ctrl: RTL and testbench

Memory-stage controller that sequences every data access from the MEM stage onto the off-chip 16-bit SRAM. A 32-bit word is moved as two halfword phases with programmable wait states. While the access is in flight, `ready` is held low so the pipeline (including the MEM/WB register) freezes. Loaded data is presented to the MEM/WB register on the cycle `ready` returns high.

---
 rtl/mem_sram_ctrl.sv | 112 +++++++++++
 tb/tb_mem_sram_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mem_sram_ctrl.sv
// mem_sram_ctrl -- MEM-stage controller for a 16-bit off-chip SRAM.
// Each 32-bit access runs as two halfword phases (LOW, then HIGH).
// Each phase lasts WAIT cycles. ready stays low for the whole access so the
// pipeline freezes.
//
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   rd_en, wr_en       load / store request, held until ready
//   address            byte address (BASE maps to SRAM word 0)
//   write_data         store data
//   read_data          registered load data, valid from the DONE cycle
//   ready              MEM stage may advance
//   sram_addr          SRAM halfword address
//   sram_dq_o/_i/_oe   SRAM data bus out / in / drive enable
//   sram_we_n          SRAM write strobe, active-low
module mem_sram_ctrl #(
   parameter int          WAIT = 4,
   parameter logic [31:0] BASE = 32'd1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rd_en,
   input  logic        wr_en,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        ready,
   output logic [17:0] sram_addr,
   output logic [15:0] sram_dq_o,
   input  logic [15:0] sram_dq_i,
   output logic        sram_dq_oe,
   output logic        sram_we_n
);

   typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

   state_t      state, state_nx;
   logic [3:0]  cnt, cnt_nx;
   logic        op_wr;
   logic [31:0] wdata_q;
   logic [16:0] widx_q;
   logic        hi_q;

   logic        req, last, active;
   logic [31:0] off;
   logic        unused_off;

   assign req  = rd_en | wr_en;
   assign last = (cnt == 4'(WAIT - 1));
   assign off  = address - BASE;
   // Word index keeps only 17 bits; higher bits wrap silently.
   assign unused_off = ^{off[31:19], off[1:0]};

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         IDLE: if (req) begin
            state_nx = LOW;
            cnt_nx   = 4'd0;
         end
         LOW, HIGH: begin
            if (last) begin
               state_nx = (state == LOW) ? HIGH : DONE;
               cnt_nx   = 4'd0;
            end else begin
               cnt_nx = cnt + 4'd1;
            end
         end
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         op_wr     <= 1'b0;
         wdata_q   <= 32'd0;
         widx_q    <= 17'd0;
         hi_q      <= 1'b0;
         read_data <= 32'd0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (state == IDLE && req) begin
            op_wr   <= wr_en;            // both strobes high -> write
            wdata_q <= write_data;
            widx_q  <= off[18:2];
            hi_q    <= 1'b0;
         end
         if (state == LOW && last) begin
            hi_q <= 1'b1;
            if (!op_wr) read_data[15:0] <= sram_dq_i;
         end
         if (state == HIGH && last && !op_wr)
            read_data[31:16] <= sram_dq_i;
      end
   end

   // sram_addr comes straight from registers, so it holds through IDLE/DONE.
   assign sram_addr  = {widx_q, hi_q};
   assign active     = (state == LOW) || (state == HIGH);
   assign sram_dq_oe = active & op_wr;
   // WE rises on the last cycle of each phase while address/data stay put.
   assign sram_we_n  = ~(active & op_wr & ~last);
   assign sram_dq_o  = !(active && op_wr) ? 16'd0 :
                       (state == HIGH)    ? wdata_q[31:16] : wdata_q[15:0];
   assign ready      = ((state == IDLE) && !req) || (state == DONE);

endmodule

// File: tb/tb_mem_sram_ctrl.sv
module tb_mem_sram_ctrl;
   localparam int W = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rd_en = 1'b0, wr_en = 1'b0;
   logic [31:0] address = '0, write_data = '0;
   logic [31:0] read_data;
   logic        ready;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_o, sram_dq_i;
   logic        sram_dq_oe, sram_we_n;

   mem_sram_ctrl #(.WAIT(W), .BASE(32'd1024)) dut (
      .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
      .address(address), .write_data(write_data),
      .read_data(read_data), .ready(ready), .sram_addr(sram_addr),
      .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i),
      .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
   );

   always #5 clk = ~clk;

   // Behavioural SRAM: write on a clock while strobed, asynchronous read.
   logic [15:0] mem [0:255];
   initial for (int i = 0; i < 256; i++) mem[i] = 16'h0;
   always @(posedge clk)
      if (sram_dq_oe && !sram_we_n) mem[sram_addr[7:0]] <= sram_dq_o;
   assign sram_dq_i = mem[sram_addr[7:0]];

   int checks = 0, errors = 0;
   logic [31:0] exp_q [$];     // expected read_data at each DONE
   logic [31:0] ref_mem [int]; // reference memory keyed by word index
   logic [31:0] last_rd = 32'h0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   function automatic logic [16:0] widx(input logic [31:0] a);
      logic [31:0] d;
      d = (a - 32'd1024) >> 2;
      return d[16:0];
   endfunction

   task automatic push_exp(input bit wr, input logic [31:0] a, input logic [31:0] d);
      logic [31:0] r;
      if (wr) ref_mem[int'(widx(a))] = d;
      else begin
         r = ref_mem.exists(int'(widx(a))) ? ref_mem[int'(widx(a))] : 32'h0;
         last_rd = r;
      end
      exp_q.push_back(last_rd);
   endtask

   // One complete access starting now (cycle 0), checked cycle by cycle.
   task automatic access(input bit wr, input bit rd, input logic [31:0] a,
                         input logic [31:0] d);
      logic [17:0] ea;
      int p;
      wr_en = wr; rd_en = rd; address = a; write_data = d;
      push_exp(wr, a, d);
      #1 chk("ready_c0", {31'b0, ready}, 32'd0);
      for (int c = 1; c <= 2*W; c++) begin
         tick();
         p  = (c - 1) % W;
         ea = {widx(a), (c > W)};
         if (c == 2) begin address = 32'hFFFF_0000; write_data = 32'h5555_AAAA; end
         chk("ready_busy", {31'b0, ready}, 32'd0);
         chk("sram_addr", {14'b0, sram_addr}, {14'b0, ea});
         if (wr) begin
            chk("w_oe", {31'b0, sram_dq_oe}, 32'd1);
            chk("w_dq", {16'b0, sram_dq_o}, {16'b0, (c > W) ? d[31:16] : d[15:0]});
            chk("w_we_n", {31'b0, sram_we_n}, {31'b0, (p == W-1)});
         end else begin
            chk("r_oe", {31'b0, sram_dq_oe}, 32'd0);
            chk("r_we_n", {31'b0, sram_we_n}, 32'd1);
         end
      end
      tick();
      chk("ready_done", {31'b0, ready}, 32'd1);
      chk("done_oe", {31'b0, sram_dq_oe}, 32'd0);
      chk("done_we_n", {31'b0, sram_we_n}, 32'd1);
      chk("done_dq", {16'b0, sram_dq_o}, 32'd0);
      chk("done_addr", {14'b0, sram_addr}, {14'b0, widx(a), 1'b1});
      if (exp_q.size() != 0) chk("read_data", read_data, exp_q.pop_front());
      else chk("sb_empty", 32'd1, 32'd0);
      wr_en = 1'b0; rd_en = 1'b0;
      tick();
   endtask

   initial begin
      int t1, t2, cyc;
      #2;
      chk("rst_ready", {31'b0, ready}, 32'd1);
      chk("rst_rdata", read_data, 32'd0);
      chk("rst_addr", {14'b0, sram_addr}, 32'd0);
      chk("rst_we_n", {31'b0, sram_we_n}, 32'd1);
      chk("rst_oe", {31'b0, sram_dq_oe}, 32'd0);
      chk("rst_dq", {16'b0, sram_dq_o}, 32'd0);
      tick(); tick();
      rst = 1'b0;
      // Idle: ready stays high.
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("idle_ready", {31'b0, ready}, 32'd1);
      end

      access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
      access(1'b0, 1'b1, 32'd1024, 32'h0);
      // Address wrap: 2^17 words above BASE lands on word 0 again.
      access(1'b1, 1'b0, 32'd1024 + 32'd4*32'd131072, 32'h1111_2222);
      access(1'b1, 1'b0, 32'd1028, 32'h3333_4444);
      access(1'b0, 1'b1, 32'd1024, 32'h0);
      access(1'b0, 1'b1, 32'd1028, 32'h0);
      // Both strobes: write, read_data left alone.
      access(1'b1, 1'b1, 32'd1032, 32'hCAFE_F00D);
      access(1'b0, 1'b1, 32'd1032, 32'h0);

      // Reset in cycle 6 of a read.
      rd_en = 1'b1; address = 32'd1024;
      for (int c = 1; c <= 6; c++) tick();
      rst = 1'b1; rd_en = 1'b0;
      #1;
      chk("mid_rst_rdata", read_data, 32'd0);
      chk("mid_rst_addr", {14'b0, sram_addr}, 32'd0);
      chk("mid_rst_ready", {31'b0, ready}, 32'd1);
      chk("mid_rst_we_n", {31'b0, sram_we_n}, 32'd1);
      chk("mid_rst_oe", {31'b0, sram_dq_oe}, 32'd0);
      tick(); rst = 1'b0; tick();
      last_rd = 32'h0;
      access(1'b0, 1'b1, 32'd1024, 32'h0);

      // Held back-to-back reads: ready pulses 2*W+2 cycles apart.
      rd_en = 1'b1; address = 32'd1028;
      push_exp(1'b0, 32'd1028, 32'h0);
      push_exp(1'b0, 32'd1028, 32'h0);
      t1 = -1; t2 = -1; cyc = 0;
      #1;
      while (t2 < 0 && cyc < 60) begin
         tick(); cyc++;
         if (ready) begin
            chk("b2b_rdata", read_data, exp_q.pop_front());
            if (t1 < 0) t1 = cyc; else t2 = cyc;
         end
      end
      rd_en = 1'b0;
      chk("b2b_first", t1, 2*W+1);
      chk("b2b_spacing", t2 - t1, 2*W+2);
      tick();
      chk("b2b_idle", {31'b0, ready}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
